// File: rtl/alu_share_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcode encoding,
// FSM state encoding and default widths.
`timescale 1ns/1ps
package alu_share_pkg;

   localparam int W_DEF  = 4;
   localparam int SW_DEF = 2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last
// time is chosen; a lone request always wins.
`timescale 1ns/1ps
module rr_arb2
   import alu_share_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       win
);

   always_comb begin
      win = req[1];
      if (req == 2'b11) begin
         win = ~last_grant;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters (IDLE/EXEC/RESP).
// Optional per-requester completion counters are built when ALU_SHARE_STATS_EN is defined.
`timescale 1ns/1ps
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int W   = W_DEF,
   parameter int SW_ = SW_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req,
   input  logic [W-1:0]   a0,
   input  logic [W-1:0]   b0,
   input  logic [SW_-1:0] s0,
   input  logic [W-1:0]   a1,
   input  logic [W-1:0]   b1,
   input  logic [SW_-1:0] s1,
   output logic [W-1:0]   alu_A,
   output logic [W-1:0]   alu_B,
   output logic [SW_-1:0] alu_S,
   input  logic [W-1:0]   alu_C,
   input  logic           alu_Co,
   output logic [1:0]     ack,
   output logic [W-1:0]   rsp_C,
   output logic           rsp_Co,
   output logic           busy,
   output logic [7:0]     stat0,
   output logic [7:0]     stat1
);

   state_t         state_q, state_d;
   logic           win_q, win_d;
   logic           last_grant_q, last_grant_d;
   logic [W-1:0]   alu_a_q, alu_a_d;
   logic [W-1:0]   alu_b_q, alu_b_d;
   logic [SW_-1:0] alu_s_q, alu_s_d;
   logic [1:0]     ack_q, ack_d;
   logic [W-1:0]   rsp_c_q, rsp_c_d;
   logic           rsp_co_q, rsp_co_d;
   logic           arb_win;

   rr_arb2 u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .win        (arb_win)
   );

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_s_d      = alu_s_q;
      ack_d        = 2'b00;
      rsp_c_d      = rsp_c_q;
      rsp_co_d     = rsp_co_q;
      case (state_q)
         IDLE: begin
            // Operand registers only move on a grant, so the ALU sees no toggling while idle.
            if (req != 2'b00) begin
               win_d   = arb_win;
               alu_a_d = arb_win ? a1 : a0;
               alu_b_d = arb_win ? b1 : b0;
               alu_s_d = arb_win ? s1 : s0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_c_d  = alu_C;
            rsp_co_d = alu_Co;
            ack_d    = win_q ? 2'b10 : 2'b01;
            state_d  = RESP;
         end
         RESP: begin
            last_grant_d = win_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         win_q        <= 1'b0;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_s_q      <= '0;
         ack_q        <= 2'b00;
         rsp_c_q      <= '0;
         rsp_co_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_s_q      <= alu_s_d;
         ack_q        <= ack_d;
         rsp_c_q      <= rsp_c_d;
         rsp_co_q     <= rsp_co_d;
      end
   end

   assign alu_A  = alu_a_q;
   assign alu_B  = alu_b_q;
   assign alu_S  = alu_s_q;
   assign ack    = ack_q;
   assign rsp_C  = rsp_c_q;
   assign rsp_Co = rsp_co_q;
   assign busy   = (state_q != IDLE);

`ifdef ALU_SHARE_STATS_EN
   logic [1:0][7:0] stat_q, stat_d;

   // Counts the ack being issued this cycle; saturates rather than wrapping.
   always_comb begin
      stat_d = stat_q;
      if (state_q == RESP && stat_q[win_q] != 8'hFF) begin
         stat_d[win_q] = stat_q[win_q] + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat0 = stat_q[0];
   assign stat1 = stat_q[1];
`else
   assign stat0 = 8'h00;
   assign stat1 = 8'h00;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by
// randomized two-requester traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req;
   logic [3:0] a0, b0, a1, b1;
   logic [1:0] s0, s1;
   logic [3:0] alu_A, alu_B, alu_C, rsp_C;
   logic [1:0] alu_S, ack;
   logic       alu_Co, rsp_Co, busy;
   logic [7:0] stat0, stat1;

   int n_cmp = 0;
   int n_bad = 0;
   int last_w = 1;
   int cnt0 = 0;
   int cnt1 = 0;

   logic [1:0] pend;
   logic [3:0] opa [2];
   logic [3:0] opb [2];
   logic [1:0] ops [2];

   always #5 clk = ~clk;

   alu_share_arbiter #(.W(4), .SW_(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a0(a0), .b0(b0), .s0(s0), .a1(a1), .b1(b1), .s1(s1),
      .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S),
      .alu_C(alu_C), .alu_Co(alu_Co),
      .ack(ack), .rsp_C(rsp_C), .rsp_Co(rsp_Co), .busy(busy),
      .stat0(stat0), .stat1(stat1)
   );

   function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s);
      case (s)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   // Stand-in for the shared ALU.
   assign {alu_Co, alu_C} = alu_ref(alu_A, alu_B, alu_S);

   function automatic int pick(input logic [1:0] r, input int lst);
      if (r == 2'b11) return 1 - lst;
      return r[1] ? 1 : 0;
   endfunction

   function automatic logic [31:0] sat_exp(input int c);
`ifdef ALU_SHARE_STATS_EN
      return (c > 255) ? 32'd255 : 32'(c);
`else
      return (c < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      last_w = 1;
      cnt0 = 0;
      cnt1 = 0;
   endtask

   task automatic drive();
      req = pend;
      a0 = opa[0]; b0 = opb[0]; s0 = ops[0];
      a1 = opa[1]; b1 = opb[1]; s1 = ops[1];
   endtask

   task automatic new_op(input int r);
      opa[r] = 4'($urandom_range(0, 15));
      opb[r] = 4'($urandom_range(0, 15));
      ops[r] = 2'($urandom_range(0, 3));
   endtask

   // Called with the DUT idle and req already driven; returns in the ack cycle.
   task automatic op_check(input int w, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [1:0] es);
      logic [4:0] r;
      r = alu_ref(ea, eb, es);
      tick();
      check("alu_A", 32'(alu_A), 32'(ea));
      check("alu_B", 32'(alu_B), 32'(eb));
      check("alu_S", 32'(alu_S), 32'(es));
      check("busy_exec", 32'(busy), 32'd1);
      check("ack_exec", 32'(ack), 32'd0);
      tick();
      check("ack_resp", 32'(ack), (w == 1) ? 32'd2 : 32'd1);
      check("rsp_C", 32'(rsp_C), 32'(r[3:0]));
      check("rsp_Co", 32'(rsp_Co), 32'(r[4]));
      check("busy_resp", 32'(busy), 32'd1);
      $display("op r%0d A=%h B=%h S=%0d -> C=%h Co=%b ack=%b", w, ea, eb, es, rsp_C, rsp_Co, ack);
      last_w = w;
      if (w == 1) cnt1++; else cnt0++;
   endtask

   initial begin
      req = 2'b00;
      a0 = '0; b0 = '0; s0 = '0; a1 = '0; b1 = '0; s1 = '0;
      pend = 2'b00;
      for (int i = 0; i < 2; i++) begin
         opa[i] = '0; opb[i] = '0; ops[i] = '0;
      end

      // Reset state
      #12;
      check("rst_alu_A", 32'(alu_A), 32'd0);
      check("rst_alu_B", 32'(alu_B), 32'd0);
      check("rst_alu_S", 32'(alu_S), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_rsp_C", 32'(rsp_C), 32'd0);
      check("rst_rsp_Co", 32'(rsp_Co), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stat0", 32'(stat0), 32'd0);
      check("rst_stat1", 32'(stat1), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single requester 0: 9+8
      req = 2'b01; a0 = 4'd9; b0 = 4'd8; s0 = OP_ADD;
      op_check(0, 4'd9, 4'd8, OP_ADD);
      check("t1_rsp_C", 32'(rsp_C), 32'd1);
      check("t1_rsp_Co", 32'(rsp_Co), 32'd1);
      req = 2'b00;
      tick();
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_ack", 32'(ack), 32'd0);
      tick();
      check("t1_hold_A", 32'(alu_A), 32'd9);
      check("t1_hold_B", 32'(alu_B), 32'd8);

      // Simultaneous requests from reset: r0 wins first
      do_reset();
      req = 2'b11;
      a0 = 4'd3; b0 = 4'd5; s0 = OP_AND;
      a1 = 4'hA; b1 = 4'd5; s1 = OP_OR;
      op_check(pick(2'b11, last_w), 4'd3, 4'd5, OP_AND);
      check("t2_first_C", 32'(rsp_C), 32'd1);
      req = 2'b10;
      tick();
      check("t2_gap_busy", 32'(busy), 32'd0);
      op_check(1, 4'hA, 4'd5, OP_OR);
      check("t2_second_C", 32'(rsp_C), 32'hF);
      req = 2'b00;
      tick();

      // Both held 12 cycles: strict alternation, one idle cycle between ops
      do_reset();
      req = 2'b11;
      opa[0] = 4'd3;  opb[0] = 4'd5; ops[0] = OP_ADD;
      opa[1] = 4'd12; opb[1] = 4'd7; ops[1] = OP_SUB;
      a0 = opa[0]; b0 = opb[0]; s0 = ops[0];
      a1 = opa[1]; b1 = opb[1]; s1 = ops[1];
      begin
         int w;
         logic [4:0] r;
         w = 0;
         for (int n = 1; n <= 12; n++) begin
            tick();
            if (n % 3 == 1) begin
               w = pick(2'b11, last_w);
               check("held_busy_exec", 32'(busy), 32'd1);
               check("held_ack_exec", 32'(ack), 32'd0);
            end else if (n % 3 == 2) begin
               r = alu_ref(opa[w], opb[w], ops[w]);
               check("held_ack", 32'(ack), (w == 1) ? 32'd2 : 32'd1);
               check("held_rsp_C", 32'(rsp_C), 32'(r[3:0]));
               $display("held cycle %0d ack=%b C=%h", n, ack, rsp_C);
               last_w = w;
               if (w == 1) cnt1++; else cnt0++;
            end else begin
               check("held_busy_idle", 32'(busy), 32'd0);
               check("held_ack_idle", 32'(ack), 32'd0);
            end
         end
      end
      req = 2'b00;
      tick();

      // Reset during EXEC drops the op
      req = 2'b01; a0 = 4'd4; b0 = 4'd4; s0 = OP_ADD;
      tick();
      check("mid_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      req = 2'b00;
      #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_ack", 32'(ack), 32'd0);
      check("mid_alu_A", 32'(alu_A), 32'd0);
      check("mid_alu_B", 32'(alu_B), 32'd0);
      check("mid_rsp_C", 32'(rsp_C), 32'd0);
      check("mid_rsp_Co", 32'(rsp_Co), 32'd0);
      #1;
      rst_n = 1'b1;
      last_w = 1; cnt0 = 0; cnt1 = 0;
      req = 2'b10; a1 = 4'd6; b1 = 4'd3; s1 = OP_SUB;
      op_check(1, 4'd6, 4'd3, OP_SUB);
      req = 2'b00;
      tick();

      // Operand change during EXEC is ignored
      req = 2'b01; a0 = 4'd2; b0 = 4'd1; s0 = OP_SUB;
      tick();
      check("iso_alu_A", 32'(alu_A), 32'd2);
      a0 = 4'd7;
      tick();
      check("iso_ack", 32'(ack), 32'd1);
      check("iso_rsp_C", 32'(rsp_C), 32'd1);
      check("iso_rsp_Co", 32'(rsp_Co), 32'd0);
      last_w = 0; cnt0++;
      req = 2'b00;
      tick();

      // Randomized traffic
      pend = 2'b00;
      for (int it = 0; it < 40; it++) begin
         int w;
         if (pend == 2'b00) begin
            pend = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) if (pend[r]) new_op(r);
         end
         drive();
         w = pick(pend, last_w);
         op_check(w, opa[w], opb[w], ops[w]);
         pend[w] = 1'($urandom_range(0, 1));
         if (pend[w]) new_op(w);
         if (!pend[1-w] && $urandom_range(0, 1) == 1) begin
            pend[1-w] = 1'b1;
            new_op(1 - w);
         end
         drive();
         tick();
         check("rnd_busy_idle", 32'(busy), 32'd0);
         check("rnd_ack_idle", 32'(ack), 32'd0);
      end
      pend = 2'b00;
      req = 2'b00;
      tick();
      check("rnd_stat0", 32'(stat0), sat_exp(cnt0));
      check("rnd_stat1", 32'(stat1), sat_exp(cnt1));

      // 260 requester-0 ops with req held: counter saturation
      do_reset();
      req = 2'b01;
      for (int i = 0; i < 260; i++) begin
         new_op(0);
         a0 = opa[0]; b0 = opb[0]; s0 = ops[0];
         op_check(0, opa[0], opb[0], ops[0]);
         if (i != 259) tick();
      end
      req = 2'b00;
      tick();
      tick();
      check("sat_stat0", 32'(stat0), sat_exp(cnt0));
      check("sat_stat1", 32'(stat1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
